// File: rtl/field_entry_pkg.sv
// Shared definitions for the field-entry sequencer.
//   state_t   : controller states (IDLE / ENTER / COMMIT)
//   cnt_w     : bits needed to hold a counter value 0..n-1 (at least 1)
//   field_off : bit offset of field f of channel c in a packed field bus
package field_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int field_off(input int c, input int f,
                                   input int max_fields, input int field_w);
    return (c * max_fields + f) * field_w;
  endfunction

endpackage

// File: rtl/entry_timeout_cnt.sv
// Inactivity counter for an entry in progress.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   i_clear    : force count to zero (highest priority)
//   i_enable   : count one idle cycle
//   o_tc       : count has reached TIMEOUT_CYC-1
// The count saturates at TIMEOUT_CYC-1 so it can never wrap back to zero.
module entry_timeout_cnt
  import field_entry_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int            TW     = cnt_w(TIMEOUT_CYC);
  localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst)                            r_cnt <= '0;
    else if (i_clear)                    r_cnt <= '0;
    else if (i_enable && r_cnt != TC_VAL) r_cnt <= r_cnt + TW'(1);
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/field_entry_ctrl.sv
// Multi-channel field-entry sequencer. A channel is selected with btn_sel,
// its fields are stepped through with btn_next (range-checked against
// FIELD_MIN/FIELD_MAX), and on the last field the whole channel slice is
// written to buf_out with a one-cycle commit strobe.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   btn_sel     : per-channel start pulses (lowest index wins)
//   btn_next    : accept sw_val as the current field
//   btn_cancel  : abort the entry in progress
//   sw_val      : field value from the switches
//   busy        : entry (or its commit cycle) in progress
//   ch_active   : one-hot channel being entered, 0 when idle
//   step        : index of the field being entered
//   buf_out     : committed fields, field f of channel c at (c*MAX_FIELDS+f)*FIELD_W
//   commit      : one-cycle strobe, channel slice just updated
//   err         : one-cycle strobe, out-of-range value rejected
//   timeout     : one-cycle strobe, entry aborted for inactivity
module field_entry_ctrl
  import field_entry_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int MAX_FIELDS = 3,
  parameter int FIELD_W    = 7,
  // 2-bit count per channel; a count of 0 wraps to mean 4 fields
  parameter logic [2*N_CH-1:0] NFIELDS = {2'd2, 2'd3, 2'd2},
  parameter logic [N_CH*MAX_FIELDS*FIELD_W-1:0] FIELD_MIN =
    {7'd0, 7'd0, 7'd0,  7'd1, 7'd1, 7'd0,   7'd0, 7'd0, 7'd0},
  parameter logic [N_CH*MAX_FIELDS*FIELD_W-1:0] FIELD_MAX =
    {7'd0, 7'd59, 7'd23, 7'd31, 7'd12, 7'd99, 7'd0, 7'd59, 7'd23},
  parameter logic [N_CH*MAX_FIELDS*FIELD_W-1:0] RST_VAL =
    {7'd0, 7'd0, 7'd0,  7'd22, 7'd1, 7'd21,  7'd0, 7'd0, 7'd0},
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CH-1:0]                   btn_sel,
  input  logic                              btn_next,
  input  logic                              btn_cancel,
  input  logic [FIELD_W-1:0]                sw_val,
  output logic                              busy,
  output logic [N_CH-1:0]                   ch_active,
  output logic [1:0]                        step,
  output logic [N_CH*MAX_FIELDS*FIELD_W-1:0] buf_out,
  output logic [N_CH-1:0]                   commit,
  output logic                              err,
  output logic                              timeout
);

  localparam int BUF_W   = N_CH * MAX_FIELDS * FIELD_W;
  localparam int SLICE_W = MAX_FIELDS * FIELD_W;
  localparam int CH_W    = cnt_w(N_CH);

  state_t              r_state,     w_state_nxt;
  logic [CH_W-1:0]     r_ch,        w_ch_nxt;
  logic [1:0]          r_step,      w_step_nxt;
  logic [SLICE_W-1:0]  r_work,      w_work_nxt;
  logic [BUF_W-1:0]    r_buf,       w_buf_nxt;
  logic [N_CH-1:0]     r_commit,    w_commit_nxt;
  logic [N_CH-1:0]     r_ch_active, w_ch_active_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_err,       w_err_nxt;
  logic                r_timeout,   w_timeout_nxt;

  logic [CH_W-1:0]     w_sel_idx;
  logic [SLICE_W-1:0]  w_work_merged;
  logic [FIELD_W-1:0]  w_lo, w_hi;
  logic                w_in_range, w_last, w_tc;
  int                  w_off;

  entry_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .i_clear  ((r_state != ST_ENTER) | btn_next),
    .i_enable (~btn_cancel),
    .o_tc     (w_tc)
  );

  // Descending scan so the lowest requesting channel is assigned last and wins.
  always_comb begin
    w_sel_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (btn_sel[i]) w_sel_idx = CH_W'(i);
  end

  always_comb begin
    w_off         = field_off(int'(r_ch), int'(r_step), MAX_FIELDS, FIELD_W);
    w_lo          = FIELD_MIN[w_off +: FIELD_W];
    w_hi          = FIELD_MAX[w_off +: FIELD_W];
    w_in_range    = (sw_val >= w_lo) && (sw_val <= w_hi);
    w_last        = (r_step == NFIELDS[2*int'(r_ch) +: 2] - 2'd1);
    w_work_merged = r_work;
    w_work_merged[int'(r_step)*FIELD_W +: FIELD_W] = sw_val;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_ch_nxt        = r_ch;
    w_step_nxt      = r_step;
    w_work_nxt      = r_work;
    w_buf_nxt       = r_buf;
    w_commit_nxt    = '0;
    w_err_nxt       = 1'b0;
    w_timeout_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_step_nxt = '0;
        if (|btn_sel) begin
          w_state_nxt = ST_ENTER;
          w_ch_nxt    = w_sel_idx;
          w_work_nxt  = r_buf[int'(w_sel_idx)*SLICE_W +: SLICE_W];
        end
      end
      ST_ENTER: begin
        if (btn_cancel) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = '0;
        end else if (btn_next) begin
          if (!w_in_range) begin
            w_err_nxt = 1'b1;
          end else begin
            w_work_nxt = w_work_merged;
            if (w_last) begin
              // Commit from the merged value so the last field lands on this edge.
              w_buf_nxt[int'(r_ch)*SLICE_W +: SLICE_W] = w_work_merged;
              w_commit_nxt[r_ch] = 1'b1;
              w_state_nxt        = ST_COMMIT;
            end else begin
              w_step_nxt = r_step + 2'd1;
            end
          end
        end else if (w_tc) begin
          w_state_nxt   = ST_IDLE;
          w_step_nxt    = '0;
          w_timeout_nxt = 1'b1;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = '0;
      end
    endcase

    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_ch_active_nxt = '0;
    w_ch_active_nxt[w_ch_nxt] = w_busy_nxt;
  end

  // NOTE: buf_out is a plain register bank, so it is reset to RST_VAL like any
  // other state; the working buffer is reset too so its contents are defined.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_step      <= '0;
      r_work      <= '0;
      r_buf       <= RST_VAL;
      r_commit    <= '0;
      r_ch_active <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch        <= w_ch_nxt;
      r_step      <= w_step_nxt;
      r_work      <= w_work_nxt;
      r_buf       <= w_buf_nxt;
      r_commit    <= w_commit_nxt;
      r_ch_active <= w_ch_active_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign busy      = r_busy;
  assign ch_active = r_ch_active;
  assign step      = r_step;
  assign buf_out   = r_buf;
  assign commit    = r_commit;
  assign err       = r_err;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_field_entry_ctrl.sv
module tb_field_entry_ctrl;

  localparam int BUF_W = 63;
  localparam logic [BUF_W-1:0] RST_EXP =
    {7'd0, 7'd0, 7'd0, 7'd22, 7'd1, 7'd21, 7'd0, 7'd0, 7'd0};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       btn_sel = '0;
  logic             btn_next = 1'b0;
  logic             btn_cancel = 1'b0;
  logic [6:0]       sw_val = '0;
  logic             busy;
  logic [2:0]       ch_active;
  logic [1:0]       step;
  logic [BUF_W-1:0] buf_out;
  logic [2:0]       commit;
  logic             err;
  logic             timeout;

  int               n_vec = 0;
  int               n_err = 0;
  logic [BUF_W-1:0] exp_buf;

  field_entry_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_sel    (btn_sel),
    .btn_next   (btn_next),
    .btn_cancel (btn_cancel),
    .sw_val     (sw_val),
    .busy       (busy),
    .ch_active  (ch_active),
    .step       (step),
    .buf_out    (buf_out),
    .commit     (commit),
    .err        (err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the edge that produced them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_sel(input logic [2:0] s);
    btn_sel = s; tick(); btn_sel = '0;
  endtask

  task automatic press_next(input logic [6:0] v);
    sw_val = v; btn_next = 1'b1; tick(); btn_next = 1'b0;
  endtask

  task automatic set_exp(input int c, input int f, input logic [6:0] v);
    exp_buf[(c*3+f)*7 +: 7] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    exp_buf = RST_EXP;
    n_vec++; if (buf_out !== RST_EXP) begin n_err++; $display("FAIL reset_buf: got %h want %h", buf_out, RST_EXP); end
    n_vec++; if ({busy, ch_active, step, commit, err, timeout} !== 11'b0) begin n_err++;
      $display("FAIL reset_outs: got busy=%b ch=%b step=%0d commit=%b err=%b to=%b want all 0", busy, ch_active, step, commit, err, timeout); end
  endtask

  task automatic test_time_entry();
    press_sel(3'b001);
    n_vec++; if (busy !== 1'b1 || ch_active !== 3'b001 || step !== 2'd0) begin n_err++;
      $display("FAIL time_start: got busy=%b ch=%b step=%0d want 1 001 0", busy, ch_active, step); end
    press_next(7'd13);
    n_vec++; if (step !== 2'd1 || err !== 1'b0) begin n_err++; $display("FAIL time_step1: got step=%0d err=%b want 1 0", step, err); end
    press_sel(3'b010); // ignored while entering
    n_vec++; if (ch_active !== 3'b001 || step !== 2'd1) begin n_err++; $display("FAIL time_sel_ignored: got ch=%b step=%0d want 001 1", ch_active, step); end
    press_next(7'd45);
    set_exp(0, 0, 7'd13); set_exp(0, 1, 7'd45);
    n_vec++; if (commit !== 3'b001 || busy !== 1'b1) begin n_err++; $display("FAIL time_commit: got commit=%b busy=%b want 001 1", commit, busy); end
    n_vec++; if (buf_out !== exp_buf) begin n_err++; $display("FAIL time_buf: got %h want %h", buf_out, exp_buf); end
    tick();
    n_vec++; if (commit !== 3'b000 || busy !== 1'b0 || ch_active !== 3'b000 || step !== 2'd0) begin n_err++;
      $display("FAIL time_done: got commit=%b busy=%b ch=%b step=%0d want 000 0 000 0", commit, busy, ch_active, step); end
  endtask

  task automatic test_date_range();
    press_sel(3'b010);
    n_vec++; if (ch_active !== 3'b010) begin n_err++; $display("FAIL date_ch: got %b want 010", ch_active); end
    press_next(7'd24);
    press_next(7'd13);
    n_vec++; if (err !== 1'b1 || step !== 2'd1) begin n_err++; $display("FAIL date_month_hi: got err=%b step=%0d want 1 1", err, step); end
    press_next(7'd0);
    n_vec++; if (err !== 1'b1 || step !== 2'd1) begin n_err++; $display("FAIL date_month_lo: got err=%b step=%0d want 1 1", err, step); end
    press_next(7'd6);
    n_vec++; if (err !== 1'b0 || step !== 2'd2) begin n_err++; $display("FAIL date_month_ok: got err=%b step=%0d want 0 2", err, step); end
    press_next(7'd30);
    set_exp(1, 0, 7'd24); set_exp(1, 1, 7'd6); set_exp(1, 2, 7'd30);
    n_vec++; if (commit !== 3'b010) begin n_err++; $display("FAIL date_commit: got %b want 010", commit); end
    n_vec++; if (buf_out !== exp_buf) begin n_err++; $display("FAIL date_buf: got %h want %h", buf_out, exp_buf); end
    tick();
  endtask

  task automatic test_cancel();
    press_sel(3'b100);
    press_next(7'd7);
    btn_cancel = 1'b1; tick(); btn_cancel = 1'b0;
    n_vec++; if (busy !== 1'b0 || commit !== 3'b000 || ch_active !== 3'b000) begin n_err++;
      $display("FAIL cancel_idle: got busy=%b commit=%b ch=%b want 0 000 000", busy, commit, ch_active); end
    tick();
    n_vec++; if (buf_out !== exp_buf || buf_out[48:42] !== 7'd0) begin n_err++; $display("FAIL cancel_buf: got %h want %h", buf_out, exp_buf); end
    press_next(7'd3); // ignored while idle
    n_vec++; if (busy !== 1'b0 || buf_out !== exp_buf) begin n_err++; $display("FAIL idle_next: got busy=%b buf=%h want 0 %h", busy, buf_out, exp_buf); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    press_sel(3'b001);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (timeout !== 1'b0 || busy !== 1'b1) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL timeout_pre_next: got %0d early/idle cycles want 0", early); end
    press_next(7'd5);
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_vec++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_err++;
        $display("FAIL timeout_early: cycle %0d got to=%b busy=%b want 0 1", i, timeout, busy); end
    end
    tick();
    n_vec++; if (timeout !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL timeout_fire: got to=%b busy=%b want 1 0", timeout, busy); end
    n_vec++; if (buf_out !== exp_buf) begin n_err++; $display("FAIL timeout_buf: got %h want %h", buf_out, exp_buf); end
    tick();
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL timeout_pulse: got %b want 0", timeout); end
  endtask

  task automatic test_priority();
    press_sel(3'b110);
    n_vec++; if (ch_active !== 3'b010) begin n_err++; $display("FAIL prio_sel: got %b want 010", ch_active); end
    sw_val = 7'd50; btn_next = 1'b1; btn_cancel = 1'b1; tick(); btn_next = 1'b0; btn_cancel = 1'b0;
    n_vec++; if (busy !== 1'b0 || err !== 1'b0 || commit !== 3'b000 || step !== 2'd0) begin n_err++;
      $display("FAIL prio_cancel: got busy=%b err=%b commit=%b step=%0d want 0 0 000 0", busy, err, commit, step); end
    tick();
    n_vec++; if (buf_out !== exp_buf) begin n_err++; $display("FAIL prio_buf: got %h want %h", buf_out, exp_buf); end
  endtask

  task automatic test_reset_mid_entry();
    press_sel(3'b001);
    press_next(7'd10);
    rst = 1'b0; tick(); rst = 1'b1;
    exp_buf = RST_EXP;
    n_vec++; if (buf_out !== RST_EXP) begin n_err++; $display("FAIL rst_mid_buf: got %h want %h", buf_out, RST_EXP); end
    n_vec++; if (busy !== 1'b0 || step !== 2'd0 || ch_active !== 3'b000) begin n_err++;
      $display("FAIL rst_mid_state: got busy=%b step=%0d ch=%b want 0 0 000", busy, step, ch_active); end
    press_sel(3'b100);
    n_vec++; if (ch_active !== 3'b100 || step !== 2'd0) begin n_err++; $display("FAIL rst_mid_restart: got ch=%b step=%0d want 100 0", ch_active, step); end
  endtask

  initial begin
    test_reset();
    test_time_entry();
    test_date_range();
    test_cancel();
    test_timeout();
    test_priority();
    test_reset_mid_entry();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish within 100us");
    $fatal(1);
  end

endmodule
